// File: rtl/cdb_pkg.sv
// Shared CDB types and functional-unit ids used by the arbiter, issue logic and ROB.
package cdb_pkg;

  localparam int CDB_NUM_FU = 5;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_ROB_W  = 3;
  localparam int CDB_FU_W   = $clog2(CDB_NUM_FU);

  localparam logic [CDB_FU_W-1:0] FU_ALU   = 3'd0;
  localparam logic [CDB_FU_W-1:0] FU_BRALU = 3'd1;
  localparam logic [CDB_FU_W-1:0] FU_MUL   = 3'd2;
  localparam logic [CDB_FU_W-1:0] FU_DIV   = 3'd3;
  localparam logic [CDB_FU_W-1:0] FU_MEM   = 3'd4;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_ROB_W-1:0]  rob_idx;
    logic [CDB_FU_W-1:0]   fu_id;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins; the pointer
// moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  logic [W-1:0] ptr_q, ptr_d;
  int           idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_grant)
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : W'(int'(grant_idx) + 1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry buffer per FU, round-robin grant, registered
// broadcast. Define CDB_PERF_EN to add broadcast/conflict performance counters.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU        = CDB_NUM_FU,
  parameter int DATA_WIDTH    = CDB_DATA_W,
  parameter int ROB_IDX_WIDTH = CDB_ROB_W,
  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            flush_in,
  input  logic [NUM_FU-1:0]               req_valid_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    req_data_in,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0] req_rob_idx_in,
  output logic [NUM_FU-1:0]               req_ready_out,
  output logic                            cdb_valid_out,
  output logic [DATA_WIDTH-1:0]           cdb_data_out,
  output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx_out,
  output logic [FU_W-1:0]                 cdb_fu_id_out
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]                     broadcast_count_out,
  output logic [31:0]                     conflict_count_out
`endif
);

  // Entry fields are sized by cdb_pkg, so the width parameters must match it.
  logic [NUM_FU-1:0] full_q;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] take;
  logic [FU_W-1:0]   grant_idx;
  logic              any_grant;
  cdb_entry_t        slot_vec [NUM_FU];
  cdb_entry_t        winner;
  cdb_entry_t        cdb_entry_q, cdb_entry_d;
  logic              cdb_valid_q, cdb_valid_d;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req       (full_q),
    .advance   (!flush_in),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready_out = ~full_q | grant;
  assign take          = req_valid_in & req_ready_out;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
    logic       slot_full_q, slot_full_d;
    cdb_entry_t slot_q, slot_d;

    // A refill on the granted cycle keeps the slot full with the new result.
    always_comb begin
      slot_full_d = slot_full_q;
      slot_d      = slot_q;
      if (grant[gi]) slot_full_d = 1'b0;
      if (take[gi]) begin
        slot_full_d    = 1'b1;
        slot_d.data    = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        slot_d.rob_idx = req_rob_idx_in[gi*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
        slot_d.fu_id   = CDB_FU_W'(gi);
      end
      if (flush_in) slot_full_d = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        slot_full_q <= 1'b0;
        slot_q      <= '0;
      end else begin
        slot_full_q <= slot_full_d;
        slot_q      <= slot_d;
      end
    end

    assign full_q[gi]   = slot_full_q;
    assign slot_vec[gi] = slot_q;
  end

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (grant[i]) winner = slot_vec[i];
  end

  always_comb begin
    cdb_valid_d = any_grant && !flush_in;
    cdb_entry_d = any_grant ? winner : cdb_entry_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
    end
  end

  assign cdb_valid_out   = cdb_valid_q;
  assign cdb_data_out    = cdb_entry_q.data;
  assign cdb_rob_idx_out = cdb_entry_q.rob_idx;
  assign cdb_fu_id_out   = cdb_entry_q.fu_id;

`ifdef CDB_PERF_EN
  logic [31:0] broadcast_count_q, broadcast_count_d;
  logic [31:0] conflict_count_q, conflict_count_d;
  logic        multi_full;

  // Clearing the lowest set bit leaves something only if two or more are full.
  assign multi_full = (full_q & (full_q - {{(NUM_FU-1){1'b0}}, 1'b1})) != '0;

  always_comb begin
    broadcast_count_d = broadcast_count_q + {31'd0, cdb_valid_q};
    conflict_count_d  = conflict_count_q + {31'd0, multi_full};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      broadcast_count_q <= '0;
      conflict_count_q  <= '0;
    end else begin
      broadcast_count_q <= broadcast_count_d;
      conflict_count_q  <= conflict_count_d;
    end
  end

  assign broadcast_count_out = broadcast_count_q;
  assign conflict_count_out  = conflict_count_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic [4:0]  req_valid_in;
  logic [159:0] req_data_in;
  logic [14:0] req_rob_idx_in;
  logic [4:0]  req_ready_out;
  logic        cdb_valid_out;
  logic [31:0] cdb_data_out;
  logic [2:0]  cdb_rob_idx_out;
  logic [2:0]  cdb_fu_id_out;
`ifdef CDB_PERF_EN
  logic [31:0] broadcast_count_out;
  logic [31:0] conflict_count_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .req_valid_in    (req_valid_in),
    .req_data_in     (req_data_in),
    .req_rob_idx_in  (req_rob_idx_in),
    .req_ready_out   (req_ready_out),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_rob_idx_out (cdb_rob_idx_out),
    .cdb_fu_id_out   (cdb_fu_id_out)
`ifdef CDB_PERF_EN
    ,
    .broadcast_count_out (broadcast_count_out),
    .conflict_count_out  (conflict_count_out)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input int fu, input logic [31:0] data, input logic [2:0] tag);
    req_valid_in[fu]             = 1'b1;
    req_data_in[fu*32 +: 32]     = data;
    req_rob_idx_in[fu*3 +: 3]    = tag;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in         = 1'b0;
    flush_in       = 1'b0;
    req_valid_in   = '0;
    req_data_in    = '0;
    req_rob_idx_in = '0;

    // Reset state
    @(negedge clk_in);
    check("rst_valid", 64'(cdb_valid_out), 64'd0);
    check("rst_data", 64'(cdb_data_out), 64'd0);
    check("rst_fu", 64'(cdb_fu_id_out), 64'd0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_ready", 64'(req_ready_out), 64'h1f);

    // Single ALU result: broadcast after E1, gone after E2
    drive(0, 32'h0000_002A, 3'd3);
    @(negedge clk_in);
    req_valid_in = '0;
    check("t1_e0_valid", 64'(cdb_valid_out), 64'd0);
    @(negedge clk_in);
    check("t1_e1_valid", 64'(cdb_valid_out), 64'd1);
    check("t1_e1_data", 64'(cdb_data_out), 64'h2A);
    check("t1_e1_tag", 64'(cdb_rob_idx_out), 64'd3);
    check("t1_e1_fu", 64'(cdb_fu_id_out), 64'(FU_ALU));
    @(negedge clk_in);
    check("t1_e2_valid", 64'(cdb_valid_out), 64'd0);
    check("t1_e2_data_hold", 64'(cdb_data_out), 64'h2A);

    // All five FUs at once from pointer 0
    do_reset();
    for (int i = 0; i < 5; i++) drive(i, 32'(10 + i), 3'(i));
    @(negedge clk_in);
    req_valid_in = '0;
    check("t2_ready_e0", 64'(req_ready_out), 64'h01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check($sformatf("t2_valid_%0d", k), 64'(cdb_valid_out), 64'd1);
      check($sformatf("t2_fu_%0d", k), 64'(cdb_fu_id_out), 64'(k));
      check($sformatf("t2_data_%0d", k), 64'(cdb_data_out), 64'(10 + k));
      check($sformatf("t2_tag_%0d", k), 64'(cdb_rob_idx_out), 64'(k));
      check($sformatf("t2_ready4_%0d", k), 64'(req_ready_out[4]), 64'(k >= 3));
    end
    @(negedge clk_in);
    check("t2_done_valid", 64'(cdb_valid_out), 64'd0);
`ifdef CDB_PERF_EN
    check("perf_broadcast", 64'(broadcast_count_out), 64'd5);
    check("perf_conflict", 64'(conflict_count_out), 64'd4);
`endif

    // FU2 and FU4 hold valid: grants alternate
    drive(2, 32'h22, 3'd2);
    drive(4, 32'h44, 3'd4);
    @(negedge clk_in);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_in);
      check($sformatf("t3_valid_%0d", n), 64'(cdb_valid_out), 64'd1);
      check($sformatf("t3_fu_%0d", n), 64'(cdb_fu_id_out), (n % 2 == 1) ? 64'd4 : 64'd2);
      check($sformatf("t3_data_%0d", n), 64'(cdb_data_out), (n % 2 == 1) ? 64'h44 : 64'h22);
    end
    req_valid_in = '0;
    repeat (4) @(negedge clk_in);
    check("t3_drained_ready", 64'(req_ready_out), 64'h1f);

    // Flush with buffers 1 and 3 full; FU0 offered during flush is dropped
    drive(1, 32'h11, 3'd1);
    drive(3, 32'h33, 3'd3);
    @(negedge clk_in);
    req_valid_in = '0;
    drive(0, 32'h99, 3'd0);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    req_valid_in = '0;
    check("t4_valid_e1", 64'(cdb_valid_out), 64'd0);
    check("t4_ready_e1", 64'(req_ready_out), 64'h1f);
    @(negedge clk_in);
    check("t4_valid_e2", 64'(cdb_valid_out), 64'd0);
    @(negedge clk_in);
    check("t4_valid_e3", 64'(cdb_valid_out), 64'd0);

    // Asynchronous reset between edges while busy
    for (int i = 0; i < 3; i++) drive(i, 32'(32'h50 + i), 3'(i));
    @(negedge clk_in);
    req_valid_in = '0;
    @(negedge clk_in);
    check("t5_pre_valid", 64'(cdb_valid_out), 64'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check("t5_async_valid", 64'(cdb_valid_out), 64'd0);
    check("t5_async_data", 64'(cdb_data_out), 64'd0);
    check("t5_async_tag", 64'(cdb_rob_idx_out), 64'd0);
    check("t5_async_fu", 64'(cdb_fu_id_out), 64'd0);
    check("t5_async_ready", 64'(req_ready_out), 64'h1f);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_in);
      check($sformatf("t5_post_valid_%0d", n), 64'(cdb_valid_out), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
